// File: rtl/aes_pkg.sv
// aes_pkg: shared AES key-schedule types, constants, S-box and Rcon helpers
package aes_pkg;
    localparam int KEY_W = 128;
    typedef enum logic [1:0] {ST_IDLE, ST_EXPAND, ST_DONE} ks_state_e;
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction
    // Inverse as x^254 by square-and-multiply, then the affine transform
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] b;
        sq = x;
        b = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq = gf_mul(sq, sq);
            b = gf_mul(b, sq);
        end
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction
    function automatic logic [7:0] rcon(input logic [7:0] idx);
        logic [7:0] r;
        r = 8'h01;
        for (int i = 1; i < 10; i++) begin
            if (8'(i) < idx) r = xtime(r);
        end
        return r;
    endfunction
endpackage

// File: rtl/aes_key_round.sv
// aes_key_round: one combinational AES-128 key-expansion round
module aes_key_round
    import aes_pkg::*;
(
    input  logic [KEY_W-1:0] key_in,
    input  logic [7:0]       rcon_idx,
    output logic [KEY_W-1:0] key_out
);
    logic [31:0] rot, temp, w0, w1, w2, w3;
    always_comb begin
        rot = {key_in[103:96], key_in[127:104]};
        for (int i = 0; i < 4; i++) temp[8*i +: 8] = sbox(rot[8*i +: 8]);
        temp[7:0] = temp[7:0] ^ rcon(rcon_idx);
        w0 = key_in[31:0] ^ temp;
        w1 = key_in[63:32] ^ w0;
        w2 = key_in[95:64] ^ w1;
        w3 = key_in[127:96] ^ w2;
        key_out = {w3, w2, w1, w0};
    end
endmodule

// File: rtl/aes_key_schedule_ctrl.sv
// aes_key_schedule_ctrl: sequences AES-128 key expansion into a round-key bank; AES_KS_ZEROIZE_EN adds a zeroize port
module aes_key_schedule_ctrl
    import aes_pkg::*;
#(
    parameter int NUM_ROUNDS = 10,
    parameter int ADDR_W     = 4
) (
    input  logic              clk,
    input  logic              rst,
`ifdef AES_KS_ZEROIZE_EN
    input  logic              zeroize,
`endif
    input  logic              start,
    input  logic [KEY_W-1:0]  key_in,
    output logic              busy,
    output logic              done,
    output logic              keys_valid,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [KEY_W-1:0]  rd_key
);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_ROUNDS);
    localparam logic [7:0]        LAST_RCON = 8'(NUM_ROUNDS);
    ks_state_e        state_q, state_d;
    logic [7:0]       rcon_q, rcon_d;
    logic             busy_q, busy_d, done_q, done_d, keys_valid_q, keys_valid_d;
    logic [KEY_W-1:0] rd_key_q, rd_key_d, round_in, round_out;
    logic [KEY_W-1:0] bank_q [0:NUM_ROUNDS];
    logic [KEY_W-1:0] bank_d [0:NUM_ROUNDS];
    logic             zz;
`ifdef AES_KS_ZEROIZE_EN
    assign zz = zeroize;
`else
    assign zz = 1'b0;
`endif
    assign round_in = bank_q[rcon_q - 8'd1];
    aes_key_round u_round (
        .key_in  (round_in),
        .rcon_idx(rcon_q),
        .key_out (round_out)
    );
    always_comb begin
        state_d = state_q;
        rcon_d = rcon_q;
        busy_d = busy_q;
        done_d = 1'b0;
        keys_valid_d = keys_valid_q;
        bank_d = bank_q;
        rd_key_d = (rd_addr <= LAST_ADDR) ? bank_q[rd_addr] : '0;
        if (zz) begin
            state_d = ST_IDLE;
            rcon_d = 8'd1;
            busy_d = 1'b0;
            keys_valid_d = 1'b0;
            bank_d = '{default: '0};
            rd_key_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: if (start) begin
                    bank_d[0] = key_in;
                    rcon_d = 8'd1;
                    keys_valid_d = 1'b0;
                    busy_d = 1'b1;
                    state_d = ST_EXPAND;
                end
                ST_EXPAND: begin
                    bank_d[rcon_q] = round_out;
                    rcon_d = rcon_q + 8'd1;
                    if (rcon_q == LAST_RCON) begin
                        state_d = ST_DONE;
                        busy_d = 1'b0;
                        done_d = 1'b1;
                        keys_valid_d = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            rcon_q <= 8'd1;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            keys_valid_q <= 1'b0;
            rd_key_q <= '0;
        end else begin
            state_q <= state_d;
            rcon_q <= rcon_d;
            busy_q <= busy_d;
            done_q <= done_d;
            keys_valid_q <= keys_valid_d;
            rd_key_q <= rd_key_d;
        end
    end
    // Bank contents are don't-care after reset, so it carries no reset
    always_ff @(posedge clk) bank_q <= bank_d;
    assign busy = busy_q;
    assign done = done_q;
    assign keys_valid = keys_valid_q;
    assign rd_key = rd_key_q;
endmodule

// File: tb/tb_aes_key_schedule_ctrl.sv
// tb_aes_key_schedule_ctrl: directed self-checking bench for aes_key_schedule_ctrl
module tb_aes_key_schedule_ctrl;
    localparam logic [127:0] FIPS_KEY = 128'h3c4fcf098815f7aba6d2ae2816157e2b;
    localparam logic [127:0] FIPS_R1  = 128'h05766c2a3939a323b12c548817fefaa0;
    localparam logic [127:0] FIPS_R10 = 128'ha60c63b6c80c3fe18925eec9a8f914d0;
    localparam logic [127:0] ZERO_R1  = 128'h63636362636363626363636263636362;
    localparam logic [127:0] ZERO_R2  = 128'haafbfbf9c998989baafbfbf9c998989b;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic zeroize = 1'b0;
    logic [127:0] key_in = '0;
    logic [3:0] rd_addr = '0;
    logic busy, done, keys_valid;
    logic [127:0] rd_key;
    int checks = 0;
    int passes = 0;
    always #5 clk = ~clk;
    aes_key_schedule_ctrl dut (
        .clk(clk), .rst(rst),
`ifdef AES_KS_ZEROIZE_EN
        .zeroize(zeroize),
`endif
        .start(start), .key_in(key_in), .busy(busy), .done(done),
        .keys_valid(keys_valid), .rd_addr(rd_addr), .rd_key(rd_key)
    );
    task automatic do_start(input logic [127:0] k);
        @(negedge clk);
        key_in = k;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask
    task automatic wait_done(output int n);
        n = 1;
        while (!done && n < 30) begin
            @(negedge clk);
            n++;
        end
    endtask
    task automatic read_key(input logic [3:0] a, output logic [127:0] k);
        @(negedge clk);
        rd_addr = a;
        @(negedge clk);
        k = rd_key;
    endtask
    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks += 4;
        if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passes++;
        if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else passes++;
        if (keys_valid !== 1'b0) $display("FAIL reset_kv got %b want 0", keys_valid); else passes++;
        if (rd_key !== 128'h0) $display("FAIL reset_rd_key got %h want 0", rd_key); else passes++;
        rst = 1'b0;
    endtask
    task automatic test_fips();
        int n;
        logic [127:0] k;
        do_start(FIPS_KEY);
        checks += 2;
        if (busy !== 1'b1) $display("FAIL fips_busy got %b want 1", busy); else passes++;
        if (keys_valid !== 1'b0) $display("FAIL fips_kv_low got %b want 0", keys_valid); else passes++;
        wait_done(n);
        checks += 3;
        if (n !== 11) $display("FAIL fips_latency got %0d want 11", n); else passes++;
        if (keys_valid !== 1'b1) $display("FAIL fips_kv got %b want 1", keys_valid); else passes++;
        if (busy !== 1'b0) $display("FAIL fips_busy_done got %b want 0", busy); else passes++;
        read_key(4'd1, k);
        checks++;
        if (k !== FIPS_R1) $display("FAIL fips_r1 got %h want %h", k, FIPS_R1); else passes++;
        checks++;
        if (done !== 1'b0) $display("FAIL fips_done_pulse got %b want 0", done); else passes++;
        read_key(4'd10, k);
        checks++;
        if (k !== FIPS_R10) $display("FAIL fips_r10 got %h want %h", k, FIPS_R10); else passes++;
        read_key(4'd0, k);
        checks++;
        if (k !== FIPS_KEY) $display("FAIL fips_r0 got %h want %h", k, FIPS_KEY); else passes++;
    endtask
    task automatic test_zero_key();
        int n;
        logic [127:0] k;
        do_start(128'h0);
        wait_done(n);
        checks += 2;
        if (n !== 11) $display("FAIL zero_latency got %0d want 11", n); else passes++;
        if (keys_valid !== 1'b1) $display("FAIL zero_kv got %b want 1", keys_valid); else passes++;
        read_key(4'd1, k);
        checks++;
        if (k !== ZERO_R1) $display("FAIL zero_r1 got %h want %h", k, ZERO_R1); else passes++;
        read_key(4'd2, k);
        checks++;
        if (k !== ZERO_R2) $display("FAIL zero_r2 got %h want %h", k, ZERO_R2); else passes++;
    endtask
    task automatic test_restart_ignored();
        int n;
        logic [127:0] k;
        do_start(FIPS_KEY);
        n = 1;
        while (!done && n < 30) begin
            start = (n == 3 || n == 7);
            key_in = start ? 128'h0 : FIPS_KEY;
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        checks++;
        if (n !== 11) $display("FAIL restart_latency got %0d want 11", n); else passes++;
        read_key(4'd1, k);
        checks++;
        if (k !== FIPS_R1) $display("FAIL restart_r1 got %h want %h", k, FIPS_R1); else passes++;
        read_key(4'd10, k);
        checks++;
        if (k !== FIPS_R10) $display("FAIL restart_r10 got %h want %h", k, FIPS_R10); else passes++;
    endtask
    task automatic test_back_to_back();
        int n;
        logic [127:0] k;
        do_start(FIPS_KEY);
        wait_done(n);
        key_in = 128'h0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks += 2;
        if (busy !== 1'b0) $display("FAIL done_start_busy got %b want 0", busy); else passes++;
        if (keys_valid !== 1'b1) $display("FAIL done_start_kv got %b want 1", keys_valid); else passes++;
        read_key(4'd1, k);
        checks++;
        if (k !== FIPS_R1) $display("FAIL done_start_r1 got %h want %h", k, FIPS_R1); else passes++;
        do_start(128'h0);
        checks += 2;
        if (keys_valid !== 1'b0) $display("FAIL idle_start_kv got %b want 0", keys_valid); else passes++;
        if (busy !== 1'b1) $display("FAIL idle_start_busy got %b want 1", busy); else passes++;
        wait_done(n);
        read_key(4'd1, k);
        checks++;
        if (k !== ZERO_R1) $display("FAIL idle_start_r1 got %h want %h", k, ZERO_R1); else passes++;
    endtask
    task automatic test_rst_mid();
        int n;
        logic [127:0] k;
        rd_addr = 4'd0;
        do_start(FIPS_KEY);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks += 3;
        if (busy !== 1'b0) $display("FAIL rst_mid_busy got %b want 0", busy); else passes++;
        if (keys_valid !== 1'b0) $display("FAIL rst_mid_kv got %b want 0", keys_valid); else passes++;
        if (rd_key !== 128'h0) $display("FAIL rst_mid_rd_key got %h want 0", rd_key); else passes++;
        do_start(FIPS_KEY);
        wait_done(n);
        checks++;
        if (n !== 11) $display("FAIL rst_mid_latency got %0d want 11", n); else passes++;
        read_key(4'd10, k);
        checks++;
        if (k !== FIPS_R10) $display("FAIL rst_mid_r10 got %h want %h", k, FIPS_R10); else passes++;
    endtask
    task automatic test_out_of_range();
        logic [127:0] k;
        for (int a = 11; a < 16; a++) begin
            read_key(4'(a), k);
            checks++;
            if (k !== 128'h0) $display("FAIL oor_addr%0d got %h want 0", a, k); else passes++;
        end
        read_key(4'd0, k);
        checks++;
        if (k !== FIPS_KEY) $display("FAIL oor_r0 got %h want %h", k, FIPS_KEY); else passes++;
    endtask
`ifdef AES_KS_ZEROIZE_EN
    task automatic test_zeroize();
        logic [127:0] k;
        @(negedge clk);
        zeroize = 1'b1;
        start = 1'b1;
        key_in = FIPS_KEY;
        @(negedge clk);
        zeroize = 1'b0;
        start = 1'b0;
        checks += 3;
        if (keys_valid !== 1'b0) $display("FAIL zeroize_kv got %b want 0", keys_valid); else passes++;
        if (busy !== 1'b0) $display("FAIL zeroize_busy got %b want 0", busy); else passes++;
        if (rd_key !== 128'h0) $display("FAIL zeroize_rd_key got %h want 0", rd_key); else passes++;
        for (int a = 0; a < 11; a++) begin
            read_key(4'(a), k);
            checks++;
            if (k !== 128'h0) $display("FAIL zeroize_addr%0d got %h want 0", a, k); else passes++;
        end
        checks++;
        if (busy !== 1'b0) $display("FAIL zeroize_start_ignored got %b want 0", busy); else passes++;
    endtask
`endif
    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end
    initial begin
        test_reset();
        test_fips();
        test_zero_key();
        test_restart_ignored();
        test_back_to_back();
        test_rst_mid();
        test_out_of_range();
`ifdef AES_KS_ZEROIZE_EN
        test_zeroize();
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
